// File: rtl/param_seq_gen_pkg.sv
// -----------------------------------------------------------------------------
// param_seq_gen_pkg
// Shared encodings for the parametrised sequence generator:
//   mode_e  - sequence selector as seen on the mode port
//   state_e - control FSM states
//   seed constants for the fixed-seed sequences (FIB, LUCAS)
// -----------------------------------------------------------------------------
package param_seq_gen_pkg;

  typedef enum logic [1:0] {
    MODE_FIB    = 2'd0,
    MODE_LUCAS  = 2'd1,
    MODE_ARITH  = 2'd2,
    MODE_GENFIB = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned FIB_SEED0   = 0;
  localparam int unsigned FIB_SEED1   = 1;
  localparam int unsigned LUCAS_SEED0 = 2;
  localparam int unsigned LUCAS_SEED1 = 1;

endpackage

// File: rtl/param_seq_gen_adder.sv
// -----------------------------------------------------------------------------
// seq_term_adder
// Produces a candidate term as op_a + op_b, computed one bit wider than the
// datapath so the carry-out is visible, and flags whether the truncated
// sum exceeds the inclusive limit.
// Ports:
//   op_a, op_b  - addends (WIDTH)
//   max_value   - inclusive upper bound (WIDTH)
//   sum         - low WIDTH bits of the sum
//   carry       - carry-out of the WIDTH-bit add
//   exceed      - sum > max_value
// -----------------------------------------------------------------------------
module seq_term_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] max_value,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             exceed
);

  logic [WIDTH:0] full_sum;

  assign full_sum = {1'b0, op_a} + {1'b0, op_b};
  assign sum      = full_sum[WIDTH-1:0];
  assign carry    = full_sum[WIDTH];
  assign exceed   = full_sum[WIDTH-1:0] > max_value;

endmodule

// File: rtl/param_seq_gen.sv
// -----------------------------------------------------------------------------
// param_seq_gen
// Emits FIB / LUCAS / ARITH / GENFIB sequences over a valid/ready stream.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   start, clear       - launch a run (IDLE/DONE only), synchronous abort
//   mode               - sequence select (see param_seq_gen_pkg::mode_e)
//   seed0, seed1       - GENFIB seeds; ARITH start value and step
//   max_value          - inclusive bound on emitted terms
//   max_terms          - maximum number of terms
//   out_data/valid/ready/last, term_idx - output stream and term index
//   busy, done         - RUN / DONE state indication
//   overflow           - run ended because the next term carried out
//   term_count         - terms transferred in the last run
//
// Datapath: cur_q is the term on out_data, nxt_q the term that follows it.
// The carry and exceed flags of nxt_q are registered alongside it, so out_last
// is a function of registers only and holds still during a stall. The adder
// builds nxt_q: at launch it forms the second term, in RUN the one after nxt_q.
// -----------------------------------------------------------------------------
module param_seq_gen #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [WIDTH-1:0] max_value,
  input  logic [CNT_W-1:0] max_terms,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] term_idx,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] term_count
);

  import param_seq_gen_pkg::*;

  state_e           state_q, state_d;
  mode_e            mode_q;
  mode_e            start_mode;
  logic [WIDTH-1:0] cur_q, nxt_q, step_q, max_value_q;
  logic [CNT_W-1:0] max_terms_q, term_idx_q, term_count_q;
  logic             nxt_carry_q, nxt_exceed_q, overflow_q;

  logic [WIDTH-1:0] first_term, second_term;
  logic             empty_run, launching, transfer, is_last;
  logic [WIDTH-1:0] add_a, add_b, add_limit, add_sum;
  logic             add_carry, add_exceed;

  // ---------------------------------------------------------------------------
  // Launch-time decode from the live inputs
  // ---------------------------------------------------------------------------
  assign start_mode = mode_e'(mode);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    first_term  = seed0;
    second_term = seed1;
    case (start_mode)
      MODE_FIB: begin
        first_term  = WIDTH'(FIB_SEED0);
        second_term = WIDTH'(FIB_SEED1);
      end
      MODE_LUCAS: begin
        first_term  = WIDTH'(LUCAS_SEED0);
        second_term = WIDTH'(LUCAS_SEED1);
      end
      default: ;
    endcase
  end

  assign empty_run = (first_term > max_value) || (max_terms == '0);
  assign launching = (state_q != ST_RUN) && start && !clear;
  assign transfer  = (state_q == ST_RUN) && out_ready;
  assign is_last   = (term_idx_q == max_terms_q - CNT_W'(1)) || nxt_carry_q || nxt_exceed_q;

  // ---------------------------------------------------------------------------
  // Adder operand steering. At launch the fib-like modes pass the second seed
  // through (+0) so its exceed flag is computed by the same comparator.
  // ---------------------------------------------------------------------------
  always_comb begin
    add_a     = cur_q;
    add_b     = nxt_q;
    add_limit = max_value_q;
    if (state_q == ST_RUN) begin
      if (mode_q == MODE_ARITH) begin
        add_a = nxt_q;
        add_b = step_q;
      end
    end else begin
      add_limit = max_value;
      if (start_mode == MODE_ARITH) begin
        add_a = seed0;
        add_b = seed1;
      end else begin
        add_a = second_term;
        add_b = '0;
      end
    end
  end

  seq_term_adder #(.WIDTH(WIDTH)) u_adder (
    .op_a      (add_a),
    .op_b      (add_b),
    .max_value (add_limit),
    .sum       (add_sum),
    .carry     (add_carry),
    .exceed    (add_exceed)
  );

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (start) state_d = empty_run ? ST_DONE : ST_RUN;
        ST_RUN:           if (transfer && is_last) state_d = ST_DONE;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Datapath and run statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= MODE_FIB;
      cur_q        <= '0;
      nxt_q        <= '0;
      step_q       <= '0;
      max_value_q  <= '0;
      max_terms_q  <= '0;
      nxt_carry_q  <= 1'b0;
      nxt_exceed_q <= 1'b0;
      term_idx_q   <= '0;
      term_count_q <= '0;
      overflow_q   <= 1'b0;
    end else if (clear) begin
      term_idx_q <= '0;
    end else if (launching) begin
      mode_q       <= start_mode;
      max_value_q  <= max_value;
      max_terms_q  <= max_terms;
      step_q       <= seed1;
      cur_q        <= first_term;
      nxt_q        <= add_sum;
      nxt_carry_q  <= add_carry;
      nxt_exceed_q <= add_exceed;
      term_idx_q   <= '0;
      term_count_q <= '0;
      overflow_q   <= 1'b0;
    end else if (transfer) begin
      if (is_last) begin
        // out_data keeps the final term; the run is over.
        term_count_q <= term_idx_q + CNT_W'(1);
        overflow_q   <= nxt_carry_q;
      end else begin
        cur_q        <= nxt_q;
        nxt_q        <= add_sum;
        nxt_carry_q  <= add_carry;
        nxt_exceed_q <= add_exceed;
        term_idx_q   <= term_idx_q + CNT_W'(1);
      end
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign out_valid  = busy;
  assign out_last   = busy && is_last;
  assign out_data   = cur_q;
  assign term_idx   = term_idx_q;
  assign term_count = term_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_param_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_param_seq_gen
// Directed bench for param_seq_gen: a 32-bit instance for most runs and an
// 8-bit instance for the carry-out termination case. Expected terms are pushed
// to a scoreboard queue before each run and popped as transfers occur.
// -----------------------------------------------------------------------------
module tb_param_seq_gen;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [15:0] idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start8 = 1'b0, clear = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] seed0 = '0, seed1 = '0, max_value = '0;
  logic [7:0]  max_value8 = 8'hFF;
  logic [15:0] max_terms = '0;
  logic        out_ready = 1'b1;

  logic [31:0] out_data;
  logic        out_valid, out_last, busy, done, overflow;
  logic [15:0] term_idx, term_count;
  logic [7:0]  out_data8;
  logic        out_valid8, out_last8, busy8, done8, overflow8;
  logic [15:0] term_idx8, term_count8;

  exp_t        exp_q[$];
  logic [31:0] vals[$];
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  param_seq_gen #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .mode(mode),
    .seed0(seed0), .seed1(seed1), .max_value(max_value), .max_terms(max_terms),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .term_idx(term_idx), .busy(busy), .done(done),
    .overflow(overflow), .term_count(term_count)
  );

  param_seq_gen #(.WIDTH(8), .CNT_W(16)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .clear(clear), .mode(mode),
    .seed0(seed0[7:0]), .seed1(seed1[7:0]), .max_value(max_value8),
    .max_terms(max_terms), .out_data(out_data8), .out_valid(out_valid8),
    .out_ready(out_ready), .out_last(out_last8), .term_idx(term_idx8),
    .busy(busy8), .done(done8), .overflow(overflow8), .term_count(term_count8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Push every value in vals; the final one is flagged last when final_last.
  task automatic push_vals(input bit final_last);
    for (int i = 0; i < vals.size(); i++) begin
      exp_t e;
      e.data = vals[i];
      e.last = final_last && (i == vals.size() - 1);
      e.idx  = 16'(i);
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge. Sets start (or start8) for one edge with the given mode.
  task automatic launch(input bit use8, input logic [1:0] m);
    mode = m;
    if (use8) start8 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start8 = 1'b0;
  endtask

  // Drains the scoreboard. Each iteration runs at a negedge: a transfer will
  // happen at the next posedge when valid and (possibly new) ready are high.
  task automatic collect(input string tag, input bit use8, input bit rand_ready, input int budget);
    int          cycles = 0;
    bit          stalled = 1'b0;
    logic [31:0] held_data;
    logic        held_last;
    logic [15:0] held_idx;
    logic [31:0] d;
    logic        v, l;
    logic [15:0] ix;
    while (exp_q.size() > 0 && cycles < budget) begin
      d  = use8 ? {24'h0, out_data8} : out_data;
      v  = use8 ? out_valid8 : out_valid;
      l  = use8 ? out_last8 : out_last;
      ix = use8 ? term_idx8 : term_idx;
      if (stalled) begin
        check({tag, " stall valid"}, 64'(v), 64'd1);
        check({tag, " stall data"}, 64'(d), 64'(held_data));
        check({tag, " stall last/idx"}, {47'h0, l, ix}, {47'h0, held_last, held_idx});
      end
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      stalled = 1'b0;
      if (v && out_ready) begin
        exp_t e;
        e = exp_q.pop_front();
        check({tag, " data"}, 64'(d), 64'(e.data));
        check({tag, " last"}, 64'(l), 64'(e.last));
        check({tag, " idx"}, 64'(ix), 64'(e.idx));
      end else if (v) begin
        stalled   = 1'b1;
        held_data = d;
        held_last = l;
        held_idx  = ix;
      end
      @(negedge clk);
      cycles++;
    end
    check({tag, " terms left at timeout"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    out_ready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " data"}, 64'(out_data), 64'd0);
    check({tag, " idx/count"}, {32'h0, term_idx, term_count}, 64'd0);
    check({tag, " flags"}, {58'h0, out_valid, out_last, busy, done, overflow, out_valid8},
          64'd0);
  endtask

  initial begin
    bit saw_valid;

    // ---------------- reset state ----------------
    #2;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after reset", {62'h0, busy, out_valid}, 64'd0);

    // ---------------- FIB up to 100 ----------------
    max_value = 32'd100;
    max_terms = 16'd1000;
    vals = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89};
    push_vals(1'b1);
    launch(1'b0, 2'd0);
    collect("fib100", 1'b0, 1'b0, 40);
    check("fib100 done", 64'(done), 64'd1);
    check("fib100 count", 64'(term_count), 64'd12);
    check("fib100 overflow", 64'(overflow), 64'd0);
    check("fib100 valid low", 64'(out_valid), 64'd0);

    // ---------------- LUCAS, 5 terms (start from DONE) ----------------
    max_value = 32'hFFFF_FFFF;
    max_terms = 16'd5;
    vals = '{2, 1, 3, 4, 7};
    push_vals(1'b1);
    launch(1'b0, 2'd1);
    collect("lucas", 1'b0, 1'b0, 20);
    check("lucas done", 64'(done), 64'd1);
    check("lucas count", 64'(term_count), 64'd5);

    // ---------------- FIB with random backpressure ----------------
    max_value = 32'd100;
    max_terms = 16'd1000;
    vals = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89};
    push_vals(1'b1);
    out_ready = 1'b0;
    launch(1'b0, 2'd0);
    collect("fib_bp", 1'b0, 1'b1, 400);
    check("fib_bp count", 64'(term_count), 64'd12);

    // ---------------- ARITH, inputs changed during RUN ----------------
    seed0 = 32'd10;
    seed1 = 32'd5;
    max_value = 32'd30;
    vals = '{10, 15, 20, 25, 30};
    push_vals(1'b1);
    launch(1'b0, 2'd2);
    seed0 = 32'd40;
    seed1 = 32'd1;
    max_value = 32'd1000;
    mode = 2'd0;
    collect("arith", 1'b0, 1'b0, 20);
    check("arith count", 64'(term_count), 64'd5);

    // ARITH first term above the bound: straight to DONE.
    seed1 = 32'd5;
    max_value = 32'd30;
    launch(1'b0, 2'd2);
    saw_valid = out_valid;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      saw_valid |= out_valid;
    end
    check("arith empty valid", 64'(saw_valid), 64'd0);
    check("arith empty done/count", {47'h0, done, term_count}, {47'h0, 1'b1, 16'd0});

    // ---------------- GENFIB 3,4 up to 50 ----------------
    seed0 = 32'd3;
    seed1 = 32'd4;
    max_value = 32'd50;
    vals = '{3, 4, 7, 11, 18, 29, 47};
    push_vals(1'b1);
    launch(1'b0, 2'd3);
    collect("genfib", 1'b0, 1'b0, 30);
    check("genfib count", 64'(term_count), 64'd7);

    // ---------------- max_terms = 0 ----------------
    max_terms = 16'd0;
    launch(1'b0, 2'd0);
    check("zero terms", {46'h0, out_valid, done, term_count}, {46'h0, 1'b0, 1'b1, 16'd0});

    // ---------------- 8-bit FIB ends on carry-out ----------------
    max_terms = 16'd1000;
    vals = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
    push_vals(1'b1);
    launch(1'b1, 2'd0);
    collect("fib8", 1'b1, 1'b0, 40);
    check("fib8 done", 64'(done8), 64'd1);
    check("fib8 count", 64'(term_count8), 64'd14);
    check("fib8 overflow", 64'(overflow8), 64'd1);

    // ---------------- clear after the third transfer ----------------
    max_value = 32'd100;
    vals = '{0, 1, 1};
    push_vals(1'b0);
    launch(1'b0, 2'd0);
    collect("clr", 1'b0, 1'b0, 10);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear valid/busy/done", {61'h0, out_valid, busy, done}, 64'd0);

    // clear and start together: clear wins, block stays idle.
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    check("clear beats start", {62'h0, busy, out_valid}, 64'd0);

    // ---------------- reset pulse mid-run ----------------
    launch(1'b0, 2'd0);
    @(negedge clk);
    check("midrun valid before reset", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("resume idle", {61'h0, out_valid, busy, done}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
